uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter's TX FIFO between NREQ byte-stream requesters. It sits in front of the `uart_tx` FIFO write port and drives `txdata` and `txdata_valid`. It locks the grant for a whole packet, delimited by `last`, or until MAX_BURST bytes have been sent, so that bytes from different sources never interleave on the line. It throttles itself against `txfifo_full` because the FIFO enqueue port has no ready.

## Interface
- NREQ, 4: number of requesters; must be ≥2.
- MAX_BURST, 16: maximum bytes per grant before a forced release; must be ≥1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_data  in  NREQ×8  packed `[NREQ-1:0][7:0]`; byte from each requester.
- req_valid  in  NREQ  requester i has a byte.
- req_last  in  NREQ  byte on requester i ends its packet.
- req_ready  out  NREQ  byte on requester i is accepted this cycle (valid & ready = handshake).
- txdata  out  8  byte to the TX FIFO `enq_data`.
- txdata_valid  out  1  one-cycle enqueue strobe to the TX FIFO `enq_valid`.
- txfifo_full  in  1  TX FIFO full flag.
- flush  in  1  abort; tied to `uart_config.flush_tx`.
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- busy  out  1  high while in LOCK.

## Operation
- FSM has two states: IDLE and LOCK. Registers: `state`, `grant`, `ptr` (`$clog2(NREQ)` bits, highest-priority index), `cnt` (`$clog2(MAX_BURST+1)` bits), `txdata`, `txdata_valid`.
- IDLE, any `req_valid` set:
  - Select the first set index scanning ptr, ptr+1, … modulo NREQ.
  - Register a one-hot `grant` for that index, set cnt=0, move to LOCK.
  - No byte is accepted in IDLE; `req_ready` is all zero.
- LOCK, owner g:
  - `req_ready[g] = !txfifo_full && !txdata_valid && !flush`; all other bits are 0. This paces transfers to at most one byte every 2 clk, so `full` always reflects the previous enqueue.
  - On handshake: txdata ← req_data[g], txdata_valid ← 1 for exactly one cycle, cnt ← cnt+1.
  - The handshake releases the grant if `req_last[g]` is set or cnt+1 == MAX_BURST. Release means: state ← IDLE, grant ← 0, ptr ← (g+1) mod NREQ.
  - If the owner drops `req_valid` mid-packet, LOCK is held indefinitely and other requesters wait.
- `flush` has priority over everything:
  - From any state, the next edge gives state ← IDLE, grant ← 0, cnt ← 0, txdata_valid ← 0.
  - ptr ← (g+1) mod NREQ if in LOCK, else unchanged.
  - No handshake occurs while flush is high.
- The `req_last` of a byte that arrives while the FIFO is full is only consumed at the handshake.
- Requesters not granted are never acknowledged; they must hold data and valid stable.

## Timing
- Reset values: state=IDLE, grant=0, busy=0, ptr=0, cnt=0, txdata=8'h00, txdata_valid=0, req_ready=0.
- Reset assertion mid-packet clears everything immediately (asynchronous); no partial byte is emitted.
- Arbitration latency: req_valid rising at edge t gives grant and busy at t+1 and req_ready at t+1 if the FIFO is not full. The handshake occurs at t+1, so txdata_valid is high in the cycle after t+1.
- Back-to-back bytes from the owner handshake every 2 cycles.
- Release to next grant: on the handshake of the last byte, state is IDLE the next cycle. A new grant is issued the cycle after that, giving at least one idle cycle between owners.
- `req_ready` is combinational from state/grant/txfifo_full/txdata_valid/flush; it has no combinational path from req_valid.
- Simultaneous requests in IDLE are resolved solely by ptr; no starvation, since each owner is served within NREQ−1 grants.

## Test plan
- Single requester: req0 sends 8'hA5, 8'h5A, 8'h3C with last on 8'h3C → txdata_valid pulses 3 times, 2 clk apart, with the same bytes in order. grant=4'b0001 throughout, then 0; ptr=1.
- Contention: req1 and req3 each hold 2-byte packets from reset (ptr=0) → req1's packet completes before req3's first byte, and bytes never interleave. After req3 releases, a fresh req1 request beats a simultaneous req2 only if ptr has reached it (ptr=0 → req1 wins).
- Forced release, MAX_BURST=4: req2 streams 10 bytes without last while req0 is waiting → req2 sends 4 bytes, then req0 is granted, then req2 resumes with byte 5.
- Backpressure: txfifo_full held high for 5 cycles mid-packet → req_ready stays 0, txdata_valid stays 0, and no byte is lost or duplicated; transfer resumes 1 cycle after full drops.
- Flush mid-packet: flush is pulsed for 1 cycle after 2 of 5 bytes from req1 → the next cycle has grant=0, busy=0, no further txdata_valid, and ptr=2.
- rst_n is asserted asynchronously during LOCK → all outputs return to reset values at once, and arbitration restarts from ptr=0 after release.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between the requesters, the arbiter and the TX FIFO enqueue port.
// The master side is the environment (requesters plus FIFO); the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [7:0]           txdata;
  logic                 txdata_valid;
  logic                 txfifo_full;

  modport master (
    output req_data, req_valid, req_last, txfifo_full,
    input  req_ready, txdata, txdata_valid
  );

  modport slave (
    input  req_data, req_valid, req_last, txfifo_full,
    output req_ready, txdata, txdata_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that feeds one UART TX FIFO from NREQ byte streams.
// A grant is held until the owner's last byte or MAX_BURST bytes; enqueues are paced 1 per 2 clk.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  input  logic             flush,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      txdata_q, txdata_d;
  logic            txdata_valid_q, txdata_valid_d;

  logic [PW-1:0]   owner, owner_next, sel;
  logic [CW-1:0]   cnt_inc;
  logic            sel_found, pace_ok, hs;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner = PW'(i);
    end
    owner_next = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  end

  // Scan starts at ptr so the previous owner has lowest priority next time.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel       = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign pace_ok       = !bus.txfifo_full && !txdata_valid_q && !flush;
  assign bus.req_ready = (state_q == LOCK) ? (grant_q & {NREQ{pace_ok}}) : '0;
  assign hs            = |(bus.req_ready & bus.req_valid);
  assign cnt_inc       = cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    txdata_d       = txdata_q;
    txdata_valid_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
      if (state_q == LOCK) ptr_d = owner_next;
    end else if (state_q == IDLE) begin
      if (sel_found) begin
        grant_d      = '0;
        grant_d[sel] = 1'b1;
        cnt_d        = '0;
        state_d      = LOCK;
      end
    end else if (hs) begin
      txdata_d       = bus.req_data[owner];
      txdata_valid_d = 1'b1;
      cnt_d          = cnt_inc;
      if (bus.req_last[owner] || cnt_inc == CW'(MAX_BURST)) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      txdata_q       <= 8'h00;
      txdata_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      txdata_q       <= txdata_d;
      txdata_valid_q <= txdata_valid_d;
    end
  end

  assign grant            = grant_q;
  assign busy             = (state_q == LOCK);
  assign bus.txdata       = txdata_q;
  assign bus.txdata_valid = txdata_valid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the DUT, and a transaction-level
// round-robin model predicts the order and source of every enqueued byte.
module tb_uart_tx_arbiter;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NREQ-1:0] grant;
  logic            busy;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flush (flush),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Bit 8 of each queued entry is the last flag.
  logic [8:0]      rq [NREQ][$];
  logic [8:0]      mq [NREQ][$];
  bit              en [NREQ];
  int              exp_src[$];
  logic [7:0]      exp_byte[$];
  int              exp_ticks[$];
  int              obs_src[$];
  logic [7:0]      obs_byte[$];
  int              obs_tick[$];
  int              model_ptr, model_ptr_end;
  int              cyc;
  int              nChecks = 0;
  int              nPass = 0;
  logic            full_drv = 1'b0;
  logic            flush_drv = 1'b0;
  logic            prev_valid = 1'b0;
  logic [NREQ-1:0] hs;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic bit anyQueued();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Serve queues round-robin from model_ptr: one owner at a time, until last or MAX_BURST bytes.
  task automatic buildModel();
    int p, g, n;
    bit found;
    logic [8:0] e;
    exp_src.delete();
    exp_byte.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    p = model_ptr;
    g = 0;
    while (1) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && mq[(p + k) % NREQ].size() > 0) begin
          found = 1'b1;
          g = (p + k) % NREQ;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        e = mq[g].pop_front();
        exp_src.push_back(g);
        exp_byte.push_back(e[7:0]);
        n++;
      end while (!e[8] && n < MAX_BURST && mq[g].size() > 0);
      p = (g + 1) % NREQ;
    end
    model_ptr_end = p;
  endtask

  // One clock: drive queue heads, note handshakes, then sample #1 after the edge.
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = en[i] && (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        bus.req_data[i] = rq[i][0][7:0];
        bus.req_last[i] = rq[i][0][8];
      end else begin
        bus.req_data[i] = 8'h00;
        bus.req_last[i] = 1'b0;
      end
    end
    bus.txfifo_full = full_drv;
    flush           = flush_drv;
    #1;
    hs = bus.req_valid & bus.req_ready;
    if (full_drv || flush_drv) checkOutput("ready_blocked", bus.req_ready, '0);
    checkOutput("ready_owner_only", bus.req_ready & ~grant, '0);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        obs_src.push_back(i);
        void'(rq[i].pop_front());
      end
    end
    if (bus.txdata_valid) begin
      obs_byte.push_back(bus.txdata);
      obs_tick.push_back(cyc);
    end
    checkOutput("valid_spacing", prev_valid & bus.txdata_valid, 1'b0);
    prev_valid = bus.txdata_valid;
  endtask

  // fullMode: 0 never full, 1 full on ticks fa..fb, 2 random.
  task automatic runScenario(input string name, input int fullMode, input int fa, input int fb,
                             input int budget);
    buildModel();
    obs_src.delete();
    obs_byte.delete();
    obs_tick.delete();
    cyc = 0;
    do begin
      if (fullMode == 1)      full_drv = (cyc + 1 >= fa) && (cyc + 1 <= fb);
      else if (fullMode == 2) full_drv = ($urandom_range(0, 2) == 0);
      else                    full_drv = 1'b0;
      applyStimulus();
      if (cyc == 1 && exp_src.size() > 0) begin
        checkOutput({name, "_first_grant"}, grant, 32'(1) << exp_src[0]);
        checkOutput({name, "_first_busy"}, busy, 1'b1);
      end
    end while (cyc < budget && (anyQueued() || busy || bus.txdata_valid));
    full_drv = 1'b0;
    checkOutput({name, "_drained"}, anyQueued() || busy, 1'b0);
    checkOutput({name, "_nbytes"}, obs_byte.size(), exp_byte.size());
    checkOutput({name, "_nhandshakes"}, obs_src.size(), exp_src.size());
    for (int i = 0; i < exp_byte.size(); i++) begin
      if (i < obs_byte.size()) checkOutput($sformatf("%s_byte%0d", name, i), obs_byte[i], exp_byte[i]);
      if (i < obs_src.size())  checkOutput($sformatf("%s_src%0d", name, i), obs_src[i], exp_src[i]);
    end
    for (int i = 0; i < exp_ticks.size(); i++) begin
      if (i < obs_tick.size()) checkOutput($sformatf("%s_tick%0d", name, i), obs_tick[i], exp_ticks[i]);
    end
    exp_ticks.delete();
    model_ptr = model_ptr_end;
    checkOutput({name, "_ptr"}, dut.ptr_q, model_ptr);
    checkOutput({name, "_grant_idle"}, grant, '0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_valid = 1'b0;
    model_ptr  = 0;
  endtask

  initial begin
    int len, npk;
    bus.req_data    = '0;
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.txfifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", grant, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_txvalid", bus.txdata_valid, 1'b0);
    checkOutput("rst_txdata", bus.txdata, 8'h00);
    checkOutput("rst_ready", bus.req_ready, '0);
    checkOutput("rst_ptr", dut.ptr_q, 0);
    releaseReset();

    $display("[TB] single requester");
    rq[0].push_back({1'b0, 8'hA5});
    rq[0].push_back({1'b0, 8'h5A});
    rq[0].push_back({1'b1, 8'h3C});
    exp_ticks = '{2, 4, 6};
    runScenario("single", 0, 0, 0, 40);

    $display("[TB] forced release");
    for (int b = 0; b < 10; b++) rq[2].push_back({(b == 9), 8'(8'h20 + b)});
    rq[0].push_back({1'b1, 8'hC0});
    runScenario("burst", 0, 0, 0, 80);

    $display("[TB] backpressure");
    for (int b = 0; b < 4; b++) rq[0].push_back({(b == 3), 8'(8'h60 + b)});
    exp_ticks = '{2, 8, 10, 12};
    runScenario("backpressure", 1, 3, 7, 60);

    $display("[TB] contention");
    rst_n = 1'b0;
    #3;
    releaseReset();
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b0, 8'h31});
    rq[3].push_back({1'b1, 8'h32});
    runScenario("contend", 0, 0, 0, 60);
    rq[1].push_back({1'b1, 8'h13});
    rq[2].push_back({1'b1, 8'h21});
    runScenario("contend_ptr", 0, 0, 0, 40);

    $display("[TB] flush mid-packet");
    for (int b = 0; b < 5; b++) rq[1].push_back({(b == 4), 8'(8'h70 + b)});
    obs_byte.delete();
    cyc = 0;
    while (obs_byte.size() < 2 && cyc < 20) applyStimulus();
    checkOutput("flush_two_sent", obs_byte.size(), 2);
    flush_drv = 1'b1;
    en[1]     = 1'b0;
    applyStimulus();
    flush_drv = 1'b0;
    checkOutput("flush_grant", grant, '0);
    checkOutput("flush_busy", busy, 1'b0);
    checkOutput("flush_txvalid", bus.txdata_valid, 1'b0);
    checkOutput("flush_ptr", dut.ptr_q, 2);
    repeat (4) begin
      applyStimulus();
      checkOutput("flush_quiet", {bus.txdata_valid, grant}, '0);
    end
    rq[1].delete();
    en[1]     = 1'b1;
    model_ptr = 2;

    $display("[TB] reset during lock");
    for (int b = 0; b < 4; b++) rq[3].push_back({(b == 3), 8'(8'h80 + b)});
    cyc = 0;
    while (!bus.txdata_valid && cyc < 10) applyStimulus();
    checkOutput("arst_pre_valid", bus.txdata_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_txvalid", bus.txdata_valid, 1'b0);
    checkOutput("arst_txdata", bus.txdata, 8'h00);
    checkOutput("arst_grant", grant, '0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_ready", bus.req_ready, '0);
    checkOutput("arst_ptr", dut.ptr_q, 0);
    rq[3].delete();
    bus.req_valid = '0;
    releaseReset();
    rq[3].push_back({1'b1, 8'h41});
    rq[1].push_back({1'b1, 8'h42});
    runScenario("restart", 0, 0, 0, 40);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 8; r++) begin
      for (int q = 0; q < NREQ; q++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) rq[q].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      runScenario($sformatf("rand%0d", r), 2, 0, 0, 600);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
